prs_ber_checker: RTL and testbench

- Parametrised, synthesizable PRS checker and BER meter.
- Replaces the ad-hoc bit packing and file-dump checking around the Fano decoder test chain.
- Takes the decoded bit stream (dec_sym/dec_vld), self-synchronises a local LFSR to the incoming pseudo-random sequence, and detects inverted polarity.
- Reports per-window error and bit counts, and declares loss of sync from a runtime threshold.

---
 rtl/prs_ber_checker.sv | 167 ++++++++++++++++
 tb/tb_prs_ber_checker.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prs_ber_checker.sv
// PRS checker and BER meter: self-synchronises a local Fibonacci LFSR to the
// decoded bit stream, detects inverted polarity, counts errors per window of
// valid bits and drops lock when a window exceeds the loss threshold.
module prs_ber_checker #(
  parameter int                 PRS_LEN   = 15,
  parameter logic [PRS_LEN-1:0] PRS_POLY  = 15'h6000,
  parameter int                 SYNC_BITS = 32,
  parameter int                 WIN_WIDTH = 24,
  parameter int                 CNT_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_vld,
  input  logic                 i_sym,
  input  logic [WIN_WIDTH-1:0] i_window,
  input  logic [WIN_WIDTH-1:0] i_loss_thr,
  output logic                 o_sync,
  output logic                 o_inverted,
  output logic                 o_res_vld,
  output logic [CNT_WIDTH-1:0] o_err_cnt,
  output logic [CNT_WIDTH-1:0] o_bit_cnt,
  output logic                 o_sync_loss
);

  localparam int LCW = $clog2(PRS_LEN + 1);
  localparam int MCW = $clog2(SYNC_BITS + 1);
  localparam int MW  = (WIN_WIDTH > CNT_WIDTH) ? WIN_WIDTH : CNT_WIDTH;

  localparam logic [LCW-1:0] LOAD_LAST  = LCW'(PRS_LEN - 1);
  localparam logic [MCW-1:0] MATCH_LAST = MCW'(SYNC_BITS - 1);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]           state;
  logic [PRS_LEN-1:0]   lfsr;
  logic [PRS_LEN-1:0]   shift_in;
  logic [LCW-1:0]       load_cnt;
  logic [MCW-1:0]       match_cnt;
  logic                 cand;
  logic                 inv;
  logic [CNT_WIDTH-1:0] win_err;
  logic [CNT_WIDTH-1:0] win_bits;
  logic [CNT_WIDTH-1:0] err_n;
  logic [CNT_WIDTH-1:0] bits_n;
  logic [WIN_WIDTH-1:0] win_len;
  logic [WIN_WIDTH-1:0] win_thr;
  logic [WIN_WIDTH-1:0] len_eff;
  logic [WIN_WIDTH-1:0] thr_eff;
  logic                 fb;
  logic                 diff;
  logic                 first_cmp;
  logic                 cand_eff;
  logic                 agree;
  logic                 win_first;
  logic                 win_done;
  logic                 win_lost;

  // Feedback, polarity comparison and next window totals for the current bit
  always_comb begin
    fb        = ^(lfsr & PRS_POLY);
    shift_in  = {lfsr[PRS_LEN-2:0], i_sym};
    diff      = i_sym ^ fb;
    first_cmp = (match_cnt == '0);
    cand_eff  = first_cmp ? diff : cand;
    agree     = first_cmp || (diff == cand);
    win_first = (win_bits == '0);
    len_eff   = win_first ? ((i_window == '0) ? WIN_WIDTH'(1) : i_window) : win_len;
    thr_eff   = win_first ? i_loss_thr : win_thr;
    bits_n    = win_bits + CNT_WIDTH'(1);
    err_n     = ((diff ^ inv) && (win_err != '1)) ? win_err + CNT_WIDTH'(1) : win_err;
    win_done  = (MW'(bits_n) == MW'(len_eff));
    win_lost  = (MW'(err_n) > MW'(thr_eff));
  end

  // Acquisition FSM, LFSR, window counters and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_LOAD;
      lfsr        <= '0;
      load_cnt    <= '0;
      match_cnt   <= '0;
      cand        <= 1'b0;
      inv         <= 1'b0;
      win_err     <= '0;
      win_bits    <= '0;
      win_len     <= '0;
      win_thr     <= '0;
      o_sync      <= 1'b0;
      o_inverted  <= 1'b0;
      o_res_vld   <= 1'b0;
      o_err_cnt   <= '0;
      o_bit_cnt   <= '0;
      o_sync_loss <= 1'b0;
    end else begin
      o_res_vld   <= 1'b0;
      o_sync_loss <= 1'b0;
      if (i_vld) begin
        case (state)
          ST_LOAD: begin
            lfsr <= shift_in;
            if (load_cnt == LOAD_LAST) begin
              load_cnt <= '0;
              if (shift_in != '0) begin
                state     <= ST_VERIFY;
                match_cnt <= '0;
                inv       <= 1'b0;
              end
            end else begin
              load_cnt <= load_cnt + LCW'(1);
            end
          end
          ST_VERIFY: begin
            if (!agree) begin
              state     <= ST_LOAD;
              match_cnt <= '0;
            end else begin
              // Seed was loaded from raw bits; on an inverted first compare it is
              // complemented so the LFSR always runs the true (non-inverted) sequence.
              lfsr <= {lfsr[PRS_LEN-2:0] ^ {(PRS_LEN-1){first_cmp & diff}}, fb};
              cand <= cand_eff;
              if (match_cnt == MATCH_LAST) begin
                state      <= ST_LOCKED;
                match_cnt  <= '0;
                inv        <= cand_eff;
                o_sync     <= 1'b1;
                o_inverted <= cand_eff;
                win_bits   <= '0;
                win_err    <= '0;
              end else begin
                match_cnt <= match_cnt + MCW'(1);
              end
            end
          end
          ST_LOCKED: begin
            lfsr <= {lfsr[PRS_LEN-2:0], fb};
            if (win_first) begin
              win_len <= len_eff;
              win_thr <= thr_eff;
            end
            if (win_done) begin
              o_res_vld <= 1'b1;
              o_err_cnt <= err_n;
              o_bit_cnt <= bits_n;
              win_bits  <= '0;
              win_err   <= '0;
              if (win_lost) begin
                state       <= ST_LOAD;
                load_cnt    <= '0;
                inv         <= 1'b0;
                o_sync      <= 1'b0;
                o_inverted  <= 1'b0;
                o_sync_loss <= 1'b1;
              end
            end else begin
              win_bits <= bits_n;
              win_err  <= err_n;
            end
          end
          default: state <= ST_LOAD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prs_ber_checker.sv
// Bench for prs_ber_checker: directed PRS stimulus (clean, errored, inverted,
// random, sparse, reset mid-window) against a history-based reference model
// compared every cycle, plus literal checks on lock latency and window results.
module tb_prs_ber_checker;

  localparam int PRS_LEN   = 15;
  localparam int SYNC_BITS = 32;
  localparam int WIN_WIDTH = 24;
  localparam int CNT_WIDTH = 24;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 i_vld;
  logic                 i_sym;
  logic [WIN_WIDTH-1:0] i_window;
  logic [WIN_WIDTH-1:0] i_loss_thr;
  logic                 o_sync;
  logic                 o_inverted;
  logic                 o_res_vld;
  logic [CNT_WIDTH-1:0] o_err_cnt;
  logic [CNT_WIDTH-1:0] o_bit_cnt;
  logic                 o_sync_loss;

  always #5 clk = ~clk;

  prs_ber_checker #(
    .PRS_LEN   (PRS_LEN),
    .PRS_POLY  (15'h6000),
    .SYNC_BITS (SYNC_BITS),
    .WIN_WIDTH (WIN_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_vld       (i_vld),
    .i_sym       (i_sym),
    .i_window    (i_window),
    .i_loss_thr  (i_loss_thr),
    .o_sync      (o_sync),
    .o_inverted  (o_inverted),
    .o_res_vld   (o_res_vld),
    .o_err_cnt   (o_err_cnt),
    .o_bit_cnt   (o_bit_cnt),
    .o_sync_loss (o_sync_loss)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input logic [63:0] act,
                           input logic [63:0] lo, input logic [63:0] hi);
    tests++;
    if ((^act === 1'bx) || act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference model. It keeps the last PRS_LEN bits of the sequence it
  // believes in (received bits while acquiring, predicted bits once locked)
  // and applies x[j] = x[j-14] ^ x[j-15] ^ polarity for x^15 + x^14 + 1.
  int          m_phase = 0;
  int unsigned seed_cnt = 0;
  int unsigned ver_cnt = 0;
  bit          m_cand = 1'b0;
  bit          xh[$];
  logic [CNT_WIDTH-1:0] w_bits = '0, w_err = '0;
  logic [WIN_WIDTH-1:0] w_len = '0, w_thr = '0;
  logic e_sync = 1'b0, e_inv = 1'b0, e_res = 1'b0, e_loss = 1'b0;
  logic [CNT_WIDTH-1:0] e_err = '0, e_bits = '0;

  always @(posedge clk) begin : model
    bit p, x, c, ok, allz;
    if (!reset_n) begin
      m_phase = 0; seed_cnt = 0; ver_cnt = 0; m_cand = 1'b0; xh.delete();
      w_bits = '0; w_err = '0; w_len = '0; w_thr = '0;
      e_sync = 1'b0; e_inv = 1'b0; e_res = 1'b0; e_loss = 1'b0; e_err = '0; e_bits = '0;
    end else begin
      e_res  = 1'b0;
      e_loss = 1'b0;
      if (i_vld) begin
        case (m_phase)
          0: begin
            xh.push_back(i_sym);
            if (xh.size() > PRS_LEN) void'(xh.pop_front());
            seed_cnt++;
            if (seed_cnt == PRS_LEN) begin
              seed_cnt = 0;
              allz = 1'b1;
              foreach (xh[k]) if (xh[k]) allz = 1'b0;
              if (!allz) begin
                m_phase = 1;
                ver_cnt = 0;
              end
            end
          end
          1: begin
            p  = xh[0] ^ xh[1];
            c  = i_sym ^ p;
            ok = (ver_cnt == 0) || (c == m_cand);
            if (ver_cnt == 0) m_cand = c;
            if (!ok) begin
              m_phase  = 0;
              seed_cnt = 0;
            end else begin
              xh.push_back(i_sym);
              void'(xh.pop_front());
              ver_cnt++;
              if (ver_cnt == SYNC_BITS) begin
                m_phase = 2;
                e_sync  = 1'b1;
                e_inv   = m_cand;
                w_bits  = '0;
                w_err   = '0;
              end
            end
          end
          default: begin
            if (w_bits == 0) begin
              w_len = (i_window == 0) ? WIN_WIDTH'(1) : i_window;
              w_thr = i_loss_thr;
            end
            x = xh[0] ^ xh[1] ^ m_cand;
            xh.push_back(x);
            void'(xh.pop_front());
            w_bits++;
            if ((i_sym != x) && (w_err != '1)) w_err++;
            if (int'(w_bits) == int'(w_len)) begin
              e_res  = 1'b1;
              e_err  = w_err;
              e_bits = w_bits;
              if (int'(w_err) > int'(w_thr)) begin
                m_phase  = 0;
                seed_cnt = 0;
                e_sync   = 1'b0;
                e_inv    = 1'b0;
                e_loss   = 1'b1;
              end
              w_bits = '0;
              w_err  = '0;
            end
          end
        endcase
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (mon_en)
      check("cycle_outputs",
            {12'h0, o_sync, o_inverted, o_res_vld, o_sync_loss, o_err_cnt, o_bit_cnt},
            {12'h0, e_sync, e_inv, e_res, e_loss, e_err, e_bits});
  end

  logic [14:0] g = 15'h0001;
  int unsigned inj_cnt = 0;

  task automatic next_prs(output bit b);
    b = g[14] ^ g[13];
    g = {g[13:0], b};
  endtask

  task automatic send_bit(input bit v, input bit s);
    @(negedge clk);
    i_vld = v;
    i_sym = s;
    @(posedge clk);
    #1;
  endtask

  task automatic send_prs(input bit inv_s, input bit flip);
    bit b;
    next_prs(b);
    send_bit(1'b1, b ^ inv_s ^ flip);
  endtask

  task automatic wait_lock(input bit inv_s, output int unsigned n);
    n = 0;
    while (o_sync !== 1'b1 && n < 200) begin
      send_prs(inv_s, 1'b0);
      n++;
    end
  endtask

  task automatic run_until_res(input int unsigned period, output bit got);
    int unsigned n;
    bit f;
    n = 0;
    got = 1'b0;
    while (!got && n < 1100) begin
      inj_cnt++;
      f = (period != 0) && (inj_cnt % period == 0);
      send_prs(1'b0, f);
      n++;
      got = (o_res_vld === 1'b1);
    end
  endtask

  task automatic do_reset(input int unsigned n);
    @(negedge clk);
    reset_n = 1'b0;
    i_vld   = 1'b1;
    i_sym   = 1'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
      check("reset_outputs",
            {12'h0, o_sync, o_inverted, o_res_vld, o_sync_loss, o_err_cnt, o_bit_cnt}, 64'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    i_vld   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    int unsigned n, nv, cyc;
    bit got;
    reset_n    = 1'b0;
    i_vld      = 1'b0;
    i_sym      = 1'b0;
    i_window   = 24'd1000;
    i_loss_thr = 24'd100;

    do_reset(3);
    mon_en = 1'b1;

    // Clean lock and error-free windows
    wait_lock(1'b0, n);
    check("clean_lock_bits", n, 47);
    check("clean_inverted", o_inverted, 0);
    repeat (2) begin
      run_until_res(0, got);
      check("clean_res_seen", got, 1);
      check("clean_err", o_err_cnt, 0);
      check("clean_bits", o_bit_cnt, 1000);
    end

    // One error every 30 bits, lock held
    repeat (2) begin
      run_until_res(30, got);
      check("inj_res_seen", got, 1);
      check_rng("inj_err", o_err_cnt, 33, 34);
      check("inj_bits", o_bit_cnt, 1000);
      check("inj_sync_held", o_sync, 1);
    end

    // Random input until loss, then relock on a clean stream
    n = 0;
    while (o_sync_loss !== 1'b1 && n < 3000) begin
      send_bit(1'b1, 1'($urandom));
      n++;
    end
    check("loss_pulse", o_sync_loss, 1);
    check("loss_with_res", o_res_vld, 1);
    check_rng("loss_err", o_err_cnt, 400, 600);
    check("loss_bits", o_bit_cnt, 1000);
    check("loss_sync_dropped", o_sync, 0);
    wait_lock(1'b0, n);
    check("relock_bits", n, 47);

    // Window 0 behaves as 1; window length sampled on first bit only
    i_window = '0;
    repeat (3) begin
      send_prs(1'b0, 1'b0);
      check("win0_res", o_res_vld, 1);
      check("win0_bits", o_bit_cnt, 1);
      check("win0_err", o_err_cnt, 0);
    end
    i_window = 24'd5;
    repeat (2) send_prs(1'b0, 1'b0);
    i_window = 24'd1000;
    repeat (2) send_prs(1'b0, 1'b0);
    check("win5_no_res_yet", o_res_vld, 0);
    send_prs(1'b0, 1'b0);
    check("win5_res", o_res_vld, 1);
    check("win5_bits", o_bit_cnt, 5);

    // Reset at window bit 500
    repeat (500) send_prs(1'b0, 1'b0);
    do_reset(2);
    wait_lock(1'b0, n);
    check("reset_relock_bits", n, 47);

    // Inverted stream, threshold boundary (errors == thr keeps lock)
    do_reset(2);
    i_window   = 24'd10;
    i_loss_thr = 24'd1;
    wait_lock(1'b1, n);
    check("inv_lock_bits", n, 47);
    check("inv_flag", o_inverted, 1);
    for (int k = 1; k <= 10; k++) send_prs(1'b1, k == 3);
    check("thr_eq_res", o_res_vld, 1);
    check("thr_eq_err", o_err_cnt, 1);
    check("thr_eq_bits", o_bit_cnt, 10);
    check("thr_eq_no_loss", o_sync_loss, 0);
    check("thr_eq_sync", o_sync, 1);
    for (int k = 1; k <= 10; k++) send_prs(1'b1, (k == 2) || (k == 7));
    check("thr_gt_res", o_res_vld, 1);
    check("thr_gt_err", o_err_cnt, 2);
    check("thr_gt_loss", o_sync_loss, 1);
    check("thr_gt_sync", o_sync, 0);
    check("thr_gt_inv", o_inverted, 0);

    // Sparse valid: one valid bit every 64 cycles
    do_reset(2);
    i_window   = 24'd1000;
    i_loss_thr = 24'd100;
    nv  = 0;
    cyc = 0;
    while (o_sync !== 1'b1 && nv < 100) begin
      repeat (63) send_bit(1'b0, 1'($urandom));
      send_prs(1'b0, 1'b0);
      nv++;
      cyc += 64;
    end
    check("sparse_lock_bits", nv, 47);
    check("sparse_lock_cycles", cyc, 3008);
    repeat (100) send_bit(1'b0, 1'($urandom));
    check("sparse_idle_sync", o_sync, 1);
    check("sparse_idle_no_res", o_res_vld, 0);

    @(negedge clk);
    i_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
